// File: rtl/add2_and_clip_pipe_pkg.sv
// add_clip_pkg: shared clip types and saturation helpers for add2_and_clip_pipe.
// Helpers work on a 64-bit signed carrier so any lane width up to 63 bits fits.
package add_clip_pkg;

    localparam int MAX_W = 64;

    typedef struct packed {
        logic signed [MAX_W-1:0] data;
        logic                    clip;
    } clip_result_t;

    function automatic logic signed [MAX_W-1:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic clip_result_t clip_sum(input logic signed [MAX_W-1:0] sum, input int w);
        clip_result_t r;
        r.clip = (sum > sat_max(w)) || (sum < sat_min(w));
        r.data = (sum > sat_max(w)) ? sat_max(w) : (sum < sat_min(w)) ? sat_min(w) : sum;
        return r;
    endfunction

endpackage

// File: rtl/add2_and_clip_pipe_lane.sv
// add2_and_clip_lane: one lane of the pipe, exact add in S1 and saturating clip in S2.
// Ports: clk, rst_n (async, active-low), s1_en/s2_en stage load strobes,
//        a/b signed operands, data clipped result, clip saturation flag.
module add2_and_clip_lane
    import add_clip_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             clip
);

    logic signed [WIDTH:0]     s1_sum;
    clip_result_t              r;
    logic [MAX_W-1-WIDTH:0]    unused_hi;

    assign r         = clip_sum(MAX_W'(s1_sum), WIDTH);
    assign unused_hi = r.data[MAX_W-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum <= '0;
            data   <= '0;
            clip   <= 1'b0;
        end else begin
            if (s1_en) s1_sum <= $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
            if (s2_en) begin
                data <= r.data[WIDTH-1:0];
                clip <= r.clip;
            end
        end
    end

endmodule

// File: rtl/add2_and_clip_pipe.sv
// add2_and_clip_pipe: NCH-lane saturating adder behind a two-stage valid/ready pipeline.
// Ports: clk, rst_n (async, active-low); in1_tdata/in2_tdata/in_tlast/in_tvalid/in_tready
//        operand stream; sum_tdata/sum_clip/sum_tlast/sum_tvalid/sum_tready result stream;
//        stats_clr/stats_count per-lane saturation counters.
// Macro ADD2_AND_CLIP_PIPE_STATS_EN builds the counters; otherwise stats_count is 0.
module add2_and_clip_pipe
    import add_clip_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NCH       = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH*WIDTH-1:0]     in1_tdata,
    input  logic [NCH*WIDTH-1:0]     in2_tdata,
    input  logic                     in_tlast,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    output logic [NCH*WIDTH-1:0]     sum_tdata,
    output logic [NCH-1:0]           sum_clip,
    output logic                     sum_tlast,
    output logic                     sum_tvalid,
    input  logic                     sum_tready,
    input  logic                     stats_clr,
    output logic [NCH*CNT_WIDTH-1:0] stats_count
);

    logic s1_valid, s1_last, s1_ld, s2_ld, s1_en, s2_en;

    assign s2_ld     = !sum_tvalid || sum_tready;
    assign s1_ld     = !s1_valid || s2_ld;
    assign in_tready = s1_ld;
    // Data registers only move when a real beat arrives, so stalled outputs stay put.
    assign s1_en     = s1_ld && in_tvalid;
    assign s2_en     = s2_ld && s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            sum_tvalid <= 1'b0;
            sum_tlast  <= 1'b0;
        end else begin
            if (s1_ld) s1_valid <= in_tvalid;
            if (s1_en) s1_last <= in_tlast;
            if (s2_ld) sum_tvalid <= s1_valid;
            if (s2_en) sum_tlast <= s1_last;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        add2_and_clip_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .s1_en(s1_en),
            .s2_en(s2_en),
            .a    (in1_tdata[k*WIDTH +: WIDTH]),
            .b    (in2_tdata[k*WIDTH +: WIDTH]),
            .data (sum_tdata[k*WIDTH +: WIDTH]),
            .clip (sum_clip[k])
        );
    end

`ifdef ADD2_AND_CLIP_PIPE_STATS_EN
    for (genvar k = 0; k < NCH; k++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (stats_clr) cnt <= '0;
            else if (sum_tvalid && sum_tready && sum_clip[k] && !(&cnt)) cnt <= cnt + 1'b1;
        end
        assign stats_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
`else
    logic unused_clr;
    assign unused_clr  = stats_clr;
    assign stats_count = '0;
`endif

endmodule

// File: tb/tb_add2_and_clip_pipe.sv
// tb_add2_and_clip_pipe: directed scoreboard bench for add2_and_clip_pipe (WIDTH=16, NCH=2, CNT_WIDTH=4).
module tb_add2_and_clip_pipe;

    localparam int W  = 16;
    localparam int N  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   in1_tdata = '0, in2_tdata = '0;
    logic          in_tlast = 1'b0, in_tvalid = 1'b0;
    logic          in_tready;
    logic [31:0]   sum_tdata;
    logic [1:0]    sum_clip;
    logic          sum_tlast, sum_tvalid, sum_tready;
    logic          stats_clr = 1'b0;
    logic [7:0]    stats_count;

    logic          tready_ctl = 1'b1, bp_en = 1'b0;
    int            bp_cnt = 0;
    assign sum_tready = bp_en ? (bp_cnt % 3 == 0) : tready_ctl;

    typedef logic [34:0] exp_t;
    exp_t          q[$];
    int            n_chk = 0, n_fail = 0, n_out = 0, occ;
    logic [3:0]    cnt_m [2] = '{4'd0, 4'd0};
    logic          prev_stall = 1'b0;
    exp_t          prev_out, e;
    logic [1:0]    xclip;
    logic [31:0]   last_data = '0;

    add2_and_clip_pipe #(.WIDTH(W), .NCH(N), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_tdata(in1_tdata), .in2_tdata(in2_tdata), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .sum_tdata(sum_tdata), .sum_clip(sum_clip), .sum_tlast(sum_tlast),
        .sum_tvalid(sum_tvalid), .sum_tready(sum_tready),
        .stats_clr(stats_clr), .stats_count(stats_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        bp_cnt <= bp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic last);
        int          s;
        logic [31:0] d;
        logic [1:0]  c;
        for (int k = 0; k < 2; k++) begin
            s = int'($signed(a[k*16 +: 16])) + int'($signed(b[k*16 +: 16]));
            c[k] = (s > 32767) || (s < -32768);
            d[k*16 +: 16] = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : s[15:0];
        end
        return {last, c, d};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            cnt_m = '{4'd0, 4'd0};
        end else begin
            occ = q.size();
            check("in_tready", in_tready, !(occ == 2 && !sum_tready));
            check("stats_count", stats_count, {cnt_m[1], cnt_m[0]});
            if (prev_stall) begin
                check("stall_valid", sum_tvalid, 1);
                check("stall_hold", {sum_tlast, sum_clip, sum_tdata}, prev_out);
            end
            xclip = 2'b00;
            if (sum_tvalid && sum_tready) begin
                if (q.size() == 0) check("spurious_out", sum_tvalid, 0);
                else begin
                    e = q.pop_front();
                    check("out", {sum_tlast, sum_clip, sum_tdata}, e);
                    xclip = e[33:32];
                    last_data = sum_tdata;
                    n_out++;
                end
            end
`ifdef ADD2_AND_CLIP_PIPE_STATS_EN
            for (int k = 0; k < 2; k++)
                cnt_m[k] = stats_clr ? 4'd0 : (xclip[k] && cnt_m[k] != 4'hF) ? cnt_m[k] + 4'd1 : cnt_m[k];
`endif
            if (in_tvalid && in_tready) q.push_back(model(in1_tdata, in2_tdata, in_tlast));
            prev_stall = sum_tvalid && !sum_tready;
            prev_out = {sum_tlast, sum_clip, sum_tdata};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int i;
        in1_tdata = a;
        in2_tdata = b;
        in_tlast  = last;
        in_tvalid = 1'b1;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_tready) break;
            @(posedge clk);
            #1;
        end
        check("send_accept", i < 100, 1);
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    initial begin
        int n0;
        #12;
        check("rst_in_tready", in_tready, 1);
        check("rst_sum_tvalid", sum_tvalid, 0);
        check("rst_sum_tdata", sum_tdata, 0);
        check("rst_sum_clip", sum_clip, 0);
        check("rst_sum_tlast", sum_tlast, 0);
        check("rst_stats", stats_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'hFFFF_1234, 32'h0001_0001, 1'b1);
        @(negedge clk);
        check("lat_edge_n", sum_tvalid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_edge_n1", sum_tvalid, 1);
        check("pt_data", sum_tdata, 32'h0000_1235);
        check("pt_clip", sum_clip, 2'b00);
        check("pt_last", sum_tlast, 1);
        @(posedge clk);
        #1;

        send(32'h8000_7000, 32'hFFFF_2000, 1'b0);
        drain();
        check("sat_data", last_data, 32'h8000_7FFF);
`ifdef ADD2_AND_CLIP_PIPE_STATS_EN
        check("sat_count", stats_count, 8'h11);
`else
        check("sat_count", stats_count, 8'h00);
`endif

        n0 = n_out;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send({16'(-i), 16'(i * 16'h1000)}, {16'h8000, 16'h3000 + 16'(i)}, i == 9);
        drain();
        bp_en = 1'b0;
        check("bp_count", n_out - n0, 10);

        for (int i = 0; i < 20; i++) send(32'h8000_7FFF, 32'h8000_0001, 1'b0);
        drain();
`ifdef ADD2_AND_CLIP_PIPE_STATS_EN
        check("cnt_stick", stats_count, 8'hFF);
`else
        check("cnt_stick", stats_count, 8'h00);
`endif

        tready_ctl = 1'b0;
        send(32'h8000_7FFF, 32'h8000_0001, 1'b0);
        @(posedge clk);
        #1;
        check("clr_stalled_valid", sum_tvalid, 1);
        stats_clr  = 1'b1;
        tready_ctl = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("clr_priority", stats_count, 8'h00);
        send(32'h8000_7FFF, 32'h8000_0001, 1'b0);
        drain();
`ifdef ADD2_AND_CLIP_PIPE_STATS_EN
        check("cnt_after_clr", stats_count, 8'h11);
`else
        check("cnt_after_clr", stats_count, 8'h00);
`endif

        tready_ctl = 1'b0;
        send(32'h0001_0001, 32'h0001_0001, 1'b0);
        send(32'h0002_0002, 32'h0002_0002, 1'b0);
        check("full_in_tready", in_tready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", sum_tvalid, 0);
        check("midrst_in_tready", in_tready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tready_ctl = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        send(32'h0000_0005, 32'h0000_0005, 1'b0);
        drain();
        check("rst_first_out", last_data, 32'h0000_000A);
        check("rst_out_count", n_out - n0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
